// File: rtl/uart_rx_framer.sv
// -----------------------------------------------------------------------------
// uart_rx_framer
//   Asynchronous serial receiver: 8 data bits, LSB first, 1 stop bit, sampled
//   with an oversampling tick and a 2-of-3 majority vote around mid-bit.
//   Received bytes are buffered in a show-ahead FIFO and offered on a
//   valid/ready byte stream to the downstream packet handler.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   -> one parity bit between data and stop, sense set by PARITY_ODD
//     undefined -> 10-bit frame, parity_err tied low
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   rxd           in   serial line, idle high, asynchronous to clk
//   rx_byte       out  FIFO head byte (8'h00 while empty)
//   rx_byte_valid out  FIFO non-empty
//   rx_byte_ready in   consumer accepts head byte (pop on valid && ready)
//   frame_err     out  1-cycle pulse, stop bit sampled low
//   overrun_err   out  1-cycle pulse, byte dropped on a full FIFO
//   parity_err    out  1-cycle pulse, parity mismatch
// -----------------------------------------------------------------------------
module uart_rx_framer #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int PARITY_ODD  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  input  logic       rx_byte_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err
);

  localparam int LP_DIV_RAW = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int LP_DIV     = (LP_DIV_RAW < 1) ? 1 : LP_DIV_RAW;
  localparam int LP_TW      = (LP_DIV > 1) ? $clog2(LP_DIV) : 1;
  localparam int LP_SW      = $clog2(OVERSAMPLE);
  localparam int LP_AW      = $clog2(FIFO_DEPTH);

  localparam logic [LP_TW-1:0] LP_TICK_LAST = LP_TW'(LP_DIV - 1);
  localparam logic [LP_SW-1:0] LP_CNT_A     = LP_SW'(OVERSAMPLE / 2 - 1);
  localparam logic [LP_SW-1:0] LP_CNT_B     = LP_SW'(OVERSAMPLE / 2);
  localparam logic [LP_SW-1:0] LP_CNT_C     = LP_SW'(OVERSAMPLE / 2 + 1);
  localparam logic [LP_SW-1:0] LP_CNT_LAST  = LP_SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    ,ST_PARITY = 3'd5
`endif
  } state_t;

  // 2-of-3 majority vote
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

`ifdef UART_RX_PARITY_EN
  localparam logic LP_ODD = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  // Even sense: data ^ parity bit must be 0; odd sense: must be 1.
  function automatic logic par_mismatch(input logic [7:0] d, input logic p, input logic odd);
    return (^d) ^ p ^ odd;
  endfunction
`endif

  state_t               r_state, w_state_nx;
  logic                 r_sync1, r_sync2;
  logic [LP_TW-1:0]     r_tick_cnt;
  logic [LP_SW-1:0]     r_samp_cnt;
  logic                 r_samp_a, r_samp_b;
  logic [7:0]           r_shift;
  logic [2:0]           r_bit_idx;
  logic                 r_push_req;
  logic                 r_frame_err, r_parity_err, r_overrun_err;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [LP_AW:0]       r_wr_ptr, r_rd_ptr;

  logic w_tick, w_start_det, w_active;
  logic w_at_a, w_at_b, w_maj_pt, w_bit_end, w_maj, w_par_bad;
  logic w_shift_en, w_push_now, w_frame_now, w_parity_now, w_idx_clr, w_idx_inc;
  logic w_full, w_empty, w_pop, w_wr, w_ovr;

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic w_par_cap;
`endif

  // Two-flop synchronizer, idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_start_det = (r_state == ST_IDLE) && !r_sync2;
  assign w_tick      = (r_tick_cnt == LP_TICK_LAST);
  assign w_active    = (r_state != ST_IDLE) && (r_state != ST_BREAK);

  // Oversample tick divider, re-phased to the detected start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_start_det || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Per-bit sample position 0..OVERSAMPLE-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samp_cnt <= '0;
    end else if (w_start_det) begin
      r_samp_cnt <= '0;
    end else if (w_active && w_tick) begin
      r_samp_cnt <= (r_samp_cnt == LP_CNT_LAST) ? '0 : r_samp_cnt + 1'b1;
    end
  end

  assign w_at_a    = w_tick && (r_samp_cnt == LP_CNT_A);
  assign w_at_b    = w_tick && (r_samp_cnt == LP_CNT_B);
  assign w_maj_pt  = w_tick && (r_samp_cnt == LP_CNT_C);
  assign w_bit_end = w_tick && (r_samp_cnt == LP_CNT_LAST);
  // Third vote is the live sample taken at the decision point
  assign w_maj     = maj3(r_samp_a, r_samp_b, r_sync2);

  // Capture the first two of the three mid-bit samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samp_a <= 1'b1;
      r_samp_b <= 1'b1;
    end else begin
      if (w_at_a) r_samp_a <= r_sync2;
      if (w_at_b) r_samp_b <= r_sync2;
    end
  end

`ifdef UART_RX_PARITY_EN
  assign w_par_bad = par_mismatch(r_shift, r_par_bit, LP_ODD);
`else
  assign w_par_bad = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!r_sync2) w_state_nx = ST_START;
        else          w_state_nx = ST_IDLE;
      end
      ST_START: begin
        if (w_maj_pt && w_maj) w_state_nx = ST_IDLE;
        else if (w_bit_end)    w_state_nx = ST_DATA;
        else                   w_state_nx = ST_START;
      end
      ST_DATA: begin
        if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nx = ST_PARITY;
`else
          w_state_nx = ST_STOP;
`endif
        end else begin
          w_state_nx = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) w_state_nx = ST_STOP;
        else           w_state_nx = ST_PARITY;
      end
`endif
      // Stop is decided at mid-bit so the next start edge can be caught early
      ST_STOP: begin
        if (w_maj_pt) w_state_nx = w_maj ? ST_IDLE : ST_BREAK;
        else          w_state_nx = ST_STOP;
      end
      ST_BREAK: begin
        if (r_sync2) w_state_nx = ST_IDLE;
        else         w_state_nx = ST_BREAK;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    w_shift_en   = 1'b0;
    w_push_now   = 1'b0;
    w_frame_now  = 1'b0;
    w_parity_now = 1'b0;
    w_idx_clr    = 1'b0;
    w_idx_inc    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_cap    = 1'b0;
`endif
    case (r_state)
      ST_START: w_idx_clr = w_bit_end;
      ST_DATA: begin
        w_shift_en = w_maj_pt;
        w_idx_inc  = w_bit_end;
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: w_par_cap = w_maj_pt;
`endif
      ST_STOP: begin
        w_push_now   = w_maj_pt && w_maj && !w_par_bad;
        w_frame_now  = w_maj_pt && !w_maj;
        w_parity_now = w_maj_pt && w_par_bad;
      end
      default: begin
        w_shift_en = 1'b0;
      end
    endcase
  end

  // Receive datapath: shift register, bit index, push request, error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= 8'h00;
      r_bit_idx    <= 3'd0;
      r_push_req   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_shift_en) r_shift <= {w_maj, r_shift[7:1]};
      if (w_idx_clr)      r_bit_idx <= 3'd0;
      else if (w_idx_inc) r_bit_idx <= r_bit_idx + 3'd1;
      r_push_req   <= w_push_now;
      r_frame_err  <= w_frame_now;
      r_parity_err <= w_parity_now;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Received parity bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_bit <= 1'b0;
    end else if (w_par_cap) begin
      r_par_bit <= w_maj;
    end
  end
`endif

  // FIFO flags: pointers carry one extra wrap bit to tell full from empty
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[LP_AW] != r_rd_ptr[LP_AW]) &&
                   (r_wr_ptr[LP_AW-1:0] == r_rd_ptr[LP_AW-1:0]);
  assign w_pop   = !w_empty && rx_byte_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_wr    = r_push_req && (!w_full || w_pop);
  assign w_ovr   = r_push_req && w_full && !w_pop;

  // FIFO pointers and overrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_overrun_err <= w_ovr;
    end
  end

  // FIFO storage; r_shift holds the byte until the next frame's data bits
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[LP_AW-1:0]] <= r_shift;
  end

  assign rx_byte_valid = !w_empty;
  assign rx_byte       = w_empty ? 8'h00 : r_mem[r_rd_ptr[LP_AW-1:0]];
  assign frame_err     = r_frame_err;
  assign overrun_err   = r_overrun_err;
  assign parity_err    = r_parity_err;

endmodule

// File: tb/tb_uart_rx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_framer
//   Drives serial frames at 16 clocks per bit and compares the delivered byte
//   stream and error pulses against expectations built from the frame rules.
// -----------------------------------------------------------------------------
module tb_uart_rx_framer;

  localparam int  CLK_HZ   = 16_000_000;
  localparam int  BAUD     = 1_000_000;
  localparam int  OS       = 16;
  localparam int  DEPTH    = 16;
  localparam int  PODD     = 0;
  localparam int  BIT_CLKS = 16;
  localparam bit  PODD_B   = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_byte_ready = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_byte_valid, frame_err, overrun_err, parity_err;

  uart_rx_framer #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
    .FIFO_DEPTH(DEPTH), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .rx_byte_ready(rx_byte_ready),
    .frame_err(frame_err), .overrun_err(overrun_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int n_frame = 0, n_ovr = 0, n_par = 0, n_both = 0, stab_viol = 0;
  bit rand_ready = 1'b0;
  logic prev_hold = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  // Observer: records accepted bytes, error-pulse cycles and hold stability
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold && (!rx_byte_valid || rx_byte !== prev_byte)) stab_viol <= stab_viol + 1;
      if (rx_byte_valid && rx_byte_ready) got_q.push_back(rx_byte);
      if (frame_err === 1'b1) n_frame <= n_frame + 1;
      if (overrun_err === 1'b1) n_ovr <= n_ovr + 1;
      if (parity_err === 1'b1) n_par <= n_par + 1;
      if (frame_err === 1'b1 && parity_err === 1'b1) n_both <= n_both + 1;
      prev_hold <= rx_byte_valid && !rx_byte_ready;
      prev_byte <= rx_byte;
    end else begin
      prev_hold <= 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    if (rand_ready) rx_byte_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (BIT_CLKS) cyc();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_ok);
    logic pbit;
    pbit = (^d) ^ PODD_B ^ !par_ok;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(pbit);
`endif
    send_bit(stop_bit);
  endtask

  task automatic wait_got(input int n, input int limit);
    int k;
    k = 0;
    while (got_q.size() < n && k < limit) begin
      cyc();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxd = 1'b1;
    repeat (3) cyc();
    total++; if (rx_byte !== 8'h00) begin bad++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte); end
    total++; if (rx_byte_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rx_byte_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    total++; if (overrun_err !== 1'b0) begin bad++; $display("FAIL reset_overrun_err: got %b want 0", overrun_err); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    rst_n = 1'b1;
    repeat (20) cyc();
    total++; if (rx_byte_valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", rx_byte_valid); end
  endtask

  task automatic test_basic();
    int f0, o0;
    f0 = n_frame; o0 = n_ovr;
    got_q.delete();
    rx_byte_ready = 1'b1;
    send_frame(8'hAA, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 1'b1);
    rxd = 1'b1;
    wait_got(2, 100);
    repeat (5) cyc();
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL basic_count: got %0d want 2", got_q.size()); end
    else begin
      total++; if (got_q[0] !== 8'hAA) begin bad++; $display("FAIL basic_byte0: got %h want aa", got_q[0]); end
      total++; if (got_q[1] !== 8'h55) begin bad++; $display("FAIL basic_byte1: got %h want 55", got_q[1]); end
    end
    total++; if (n_frame != f0 || n_ovr != o0) begin bad++; $display("FAIL basic_errors: got frame+%0d ovr+%0d want 0 0", n_frame - f0, n_ovr - o0); end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = n_frame;
    got_q.delete();
    rx_byte_ready = 1'b1;
    rxd = 1'b0;
    repeat (4) cyc();
    rxd = 1'b1;
    repeat (40) cyc();
    total++; if (got_q.size() != 0 || rx_byte_valid !== 1'b0) begin bad++; $display("FAIL glitch_push: got %0d bytes valid=%b want 0", got_q.size(), rx_byte_valid); end
    total++; if (n_frame != f0) begin bad++; $display("FAIL glitch_frame_err: got +%0d want 0", n_frame - f0); end
    send_frame(8'h3C, 1'b1, 1'b1);
    rxd = 1'b1;
    wait_got(1, 100);
    repeat (5) cyc();
    total++; if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin bad++; $display("FAIL glitch_next: got %0d bytes first=%h want 1 byte 3c", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = n_frame;
    got_q.delete();
    rx_byte_ready = 1'b1;
    send_frame(8'hF0, 1'b0, 1'b1);
    rxd = 1'b0;
    repeat (40) cyc();
    total++; if (n_frame - f0 != 1) begin bad++; $display("FAIL frame_err_count: got %0d want 1", n_frame - f0); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL frame_err_push: got %0d bytes want 0", got_q.size()); end
    rxd = 1'b1;
    repeat (20) cyc();
    send_frame(8'h01, 1'b1, 1'b1);
    rxd = 1'b1;
    wait_got(1, 100);
    repeat (5) cyc();
    total++; if (got_q.size() != 1 || got_q[0] !== 8'h01) begin bad++; $display("FAIL frame_err_recover: got %0d bytes first=%h want 1 byte 01", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    total++; if (n_frame - f0 != 1) begin bad++; $display("FAIL frame_err_single: got %0d want 1", n_frame - f0); end
  endtask

  task automatic test_overrun();
    int o0;
    o0 = n_ovr;
    got_q.delete();
    rx_byte_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 1'b1);
    rxd = 1'b1;
    repeat (5) cyc();
    total++; if (n_ovr != o0) begin bad++; $display("FAIL overrun_early: got +%0d want 0", n_ovr - o0); end
    send_frame(8'h10, 1'b1, 1'b1);
    rxd = 1'b1;
    repeat (5) cyc();
    total++; if (n_ovr - o0 != 1) begin bad++; $display("FAIL overrun_count: got %0d want 1", n_ovr - o0); end
    total++; if (rx_byte_valid !== 1'b1 || rx_byte !== 8'h00) begin bad++; $display("FAIL overrun_head: got valid=%b byte=%h want 1 00", rx_byte_valid, rx_byte); end
    rx_byte_ready = 1'b1;
    wait_got(16, 200);
    repeat (5) cyc();
    total++; if (got_q.size() != 16) begin bad++; $display("FAIL overrun_drain_count: got %0d want 16", got_q.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        total++; if (got_q[i] !== 8'(i)) begin bad++; $display("FAIL overrun_drain_%0d: got %h want %h", i, got_q[i], 8'(i)); end
      end
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] fill [16];
    int o0;
    o0 = n_ovr;
    got_q.delete();
    rx_byte_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fill[i] = 8'($urandom);
      send_frame(fill[i], 1'b1, 1'b1);
    end
    // 8'h77 with a single pop placed on the stop-bit push cycle
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'(8'h77 >> i));
`ifdef UART_RX_PARITY_EN
    send_bit((^8'h77) ^ PODD_B);
`endif
    rxd = 1'b1;
    repeat (13) cyc();
    rx_byte_ready = 1'b1;
    cyc();
    rx_byte_ready = 1'b0;
    repeat (8) cyc();
    total++; if (n_ovr != o0) begin bad++; $display("FAIL fullpop_overrun: got +%0d want 0", n_ovr - o0); end
    total++; if (got_q.size() != 1 || got_q[0] !== fill[0]) begin bad++; $display("FAIL fullpop_single: got %0d bytes want 1 byte %h", got_q.size(), fill[0]); end
    rx_byte_ready = 1'b1;
    wait_got(17, 200);
    repeat (5) cyc();
    total++; if (got_q.size() != 17) begin bad++; $display("FAIL fullpop_count: got %0d want 17", got_q.size()); end
    else begin
      for (int i = 1; i < 16; i++) begin
        total++; if (got_q[i] !== fill[i]) begin bad++; $display("FAIL fullpop_order_%0d: got %h want %h", i, got_q[i], fill[i]); end
      end
      total++; if (got_q[16] !== 8'h77) begin bad++; $display("FAIL fullpop_last: got %h want 77", got_q[16]); end
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete();
    rx_byte_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'(8'h5A >> i));
    rst_n = 1'b0;
    repeat (2) cyc();
    total++; if (rx_byte_valid !== 1'b0 || rx_byte !== 8'h00) begin bad++; $display("FAIL resetmid_flush: got valid=%b byte=%h want 0 00", rx_byte_valid, rx_byte); end
    rxd = 1'b1;
    rst_n = 1'b1;
    repeat (20) cyc();
    total++; if (rx_byte_valid !== 1'b0) begin bad++; $display("FAIL resetmid_empty: got valid=%b want 0", rx_byte_valid); end
    got_q.delete();
    rx_byte_ready = 1'b1;
    send_frame(8'hC3, 1'b1, 1'b1);
    rxd = 1'b1;
    wait_got(1, 100);
    repeat (5) cyc();
    total++; if (got_q.size() != 1 || got_q[0] !== 8'hC3) begin bad++; $display("FAIL resetmid_next: got %0d bytes first=%h want 1 byte c3", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_random();
    int f0, o0, exp_bad;
    logic [7:0] d;
    bit good;
    f0 = n_frame; o0 = n_ovr; exp_bad = 0;
    got_q.delete();
    exp_q.delete();
    rand_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      good = ($urandom_range(0, 5) != 0);
      send_frame(d, good, 1'b1);
      if (good) exp_q.push_back(d);
      else exp_bad++;
      rxd = 1'b1;
      repeat (good ? $urandom_range(0, 12) : 4 + $urandom_range(0, 12)) cyc();
    end
    rand_ready = 1'b0;
    rx_byte_ready = 1'b1;
    wait_got(exp_q.size(), 400);
    repeat (5) cyc();
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL random_byte_%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
    total++; if (n_frame - f0 != exp_bad) begin bad++; $display("FAIL random_frame_err: got %0d want %0d", n_frame - f0, exp_bad); end
    total++; if (n_ovr != o0) begin bad++; $display("FAIL random_overrun: got +%0d want 0", n_ovr - o0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int p0, f0, b0;
    p0 = n_par; f0 = n_frame; b0 = n_both;
    got_q.delete();
    rx_byte_ready = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    rxd = 1'b1;
    repeat (20) cyc();
    total++; if (n_par - p0 != 1 || n_frame != f0) begin bad++; $display("FAIL parity_only: got par+%0d frame+%0d want 1 0", n_par - p0, n_frame - f0); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL parity_push: got %0d bytes want 0", got_q.size()); end
    send_frame(8'h07, 1'b0, 1'b0);
    rxd = 1'b1;
    repeat (20) cyc();
    total++; if (n_both - b0 != 1) begin bad++; $display("FAIL parity_with_frame: got %0d joint pulses want 1", n_both - b0); end
    send_frame(8'h07, 1'b1, 1'b1);
    rxd = 1'b1;
    wait_got(1, 100);
    total++; if (got_q.size() != 1 || got_q[0] !== 8'h07) begin bad++; $display("FAIL parity_good: got %0d bytes want 1 byte 07", got_q.size()); end
  endtask
`endif

  task automatic test_final();
    total++; if (stab_viol != 0) begin bad++; $display("FAIL hold_stability: got %0d violations want 0", stab_viol); end
`ifndef UART_RX_PARITY_EN
    total++; if (n_par != 0) begin bad++; $display("FAIL parity_tied: got %0d pulses want 0", n_par); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_pop();
    test_reset_mid();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_final();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
